// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver with a PC-indexed table of 2-bit saturating predictors and a mispredict flush timer.
// Optional dynamic predictor table enabled by defining BRU_DYNAMIC_PRED_EN (default: static not-taken).
module branch_resolve_unit #(
  parameter int PC_W         = 32,
  parameter int IDX_W        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic [2:0]      ex_mode,
  input  logic            ex_zero,
  input  logic            ex_neg,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            ex_pred,
  output logic            select,
  output logic            mispredict,
  output logic            flush
);

  typedef enum logic [2:0] {
    MODE_BEQ    = 3'd0,
    MODE_BNE    = 3'd1,
    MODE_BLTZ   = 3'd2,
    MODE_BGEZ   = 3'd3,
    MODE_BGTZ   = 3'd4,
    MODE_BLEZ   = 3'd5,
    MODE_ALWAYS = 3'd6,
    MODE_NEVER  = 3'd7
  } mode_e;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  logic       w_cond;
  logic       w_res;
  logic       w_taken;
  logic       w_mis_next;
  logic [3:0] w_cnt_next;
  logic [3:0] r_flush_cnt;
  logic       r_select;
  logic       r_mispredict;
  logic       r_flush;

  // Keeps PC bits outside the index field and build-dependent inputs visibly consumed.
  logic w_unused;
  assign w_unused = ^{if_pc, ex_pc, ex_pred};

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_cond = 1'b0;
    case (mode_e'(ex_mode))
      MODE_BEQ:    w_cond = ex_zero;
      MODE_BNE:    w_cond = !ex_zero;
      MODE_BLTZ:   w_cond = ex_neg;
      MODE_BGEZ:   w_cond = !ex_neg;
      MODE_BGTZ:   w_cond = !ex_neg && !ex_zero;
      MODE_BLEZ:   w_cond = ex_neg || ex_zero;
      MODE_ALWAYS: w_cond = 1'b1;
      MODE_NEVER:  w_cond = 1'b0;
      default:     w_cond = 1'b0;
    endcase
  end

  assign w_res   = ex_valid & ex_branch;
  assign w_taken = w_res & w_cond;

`ifdef BRU_DYNAMIC_PRED_EN
  localparam int DEPTH = 2 ** IDX_W;

  logic [1:0]       r_pred_tbl [DEPTH];
  logic [IDX_W-1:0] w_if_idx;
  logic [IDX_W-1:0] w_ex_idx;

  assign w_if_idx   = if_pc[IDX_W+1:2];
  assign w_ex_idx   = ex_pc[IDX_W+1:2];
  // Reads the registered contents, so a same-edge update becomes visible one cycle later.
  assign pred_taken = r_pred_tbl[w_if_idx][1];
  assign w_mis_next = w_res & (w_cond != ex_pred);

  // NOTE: the table is built from flops rather than a RAM, so every entry can be reset to weakly not-taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_pred_tbl[i] <= 2'b01;
    end else if (w_res) begin
      if (w_cond && r_pred_tbl[w_ex_idx] != 2'b11)
        r_pred_tbl[w_ex_idx] <= r_pred_tbl[w_ex_idx] + 2'b01;
      else if (!w_cond && r_pred_tbl[w_ex_idx] != 2'b00)
        r_pred_tbl[w_ex_idx] <= r_pred_tbl[w_ex_idx] - 2'b01;
    end
  end
`else
  // Static not-taken: every taken branch is a mispredict.
  assign pred_taken = 1'b0;
  assign w_mis_next = w_res & w_cond;
`endif

  // A new mispredict restarts the window instead of extending it.
  always_comb begin
    w_cnt_next = r_flush_cnt;
    if (w_mis_next)
      w_cnt_next = FLUSH_LOAD;
    else if (r_flush_cnt != 4'd0)
      w_cnt_next = r_flush_cnt - 4'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_select     <= 1'b0;
      r_mispredict <= 1'b0;
      r_flush      <= 1'b0;
      r_flush_cnt  <= 4'd0;
    end else begin
      r_select     <= w_taken;
      r_mispredict <= w_mis_next;
      r_flush      <= (w_cnt_next != 4'd0);
      r_flush_cnt  <= w_cnt_next;
    end
  end

  assign select     = r_select;
  assign mispredict = r_mispredict;
  assign flush      = r_flush;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit; expectations adapt to whether BRU_DYNAMIC_PRED_EN is defined.
module tb_branch_resolve_unit;

`ifdef BRU_DYNAMIC_PRED_EN
  localparam logic DYN = 1'b1;
`else
  localparam logic DYN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic        ex_valid;
  logic        ex_branch;
  logic [2:0]  ex_mode;
  logic        ex_zero;
  logic        ex_neg;
  logic [31:0] ex_pc;
  logic        ex_pred;
  logic        select;
  logic        mispredict;
  logic        flush;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.PC_W(32), .IDX_W(4), .FLUSH_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_pc      (if_pc),
    .pred_taken (pred_taken),
    .ex_valid   (ex_valid),
    .ex_branch  (ex_branch),
    .ex_mode    (ex_mode),
    .ex_zero    (ex_zero),
    .ex_neg     (ex_neg),
    .ex_pc      (ex_pc),
    .ex_pred    (ex_pred),
    .select     (select),
    .mispredict (mispredict),
    .flush      (flush)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] m, input logic z, input logic n, input logic p);
    ex_valid  = v;
    ex_branch = 1'b1;
    ex_mode   = m;
    ex_zero   = z;
    ex_neg    = n;
    ex_pred   = p;
  endtask

  typedef struct {
    logic [2:0] mode;
    logic       zero;
    logic       pred;
    logic       sel;
    logic       mis_dyn;
    logic       mis_sta;
    logic       pt_dyn;
  } row_t;

  row_t       rows [9];
  logic [7:0] exp_z;
  logic [7:0] exp_n;

  initial begin
    // Expected select per mode (bit index = mode) for (zero,neg)=(1,0) and (0,1).
    exp_z = 8'b0110_1001;
    exp_n = 8'b0110_0110;
    // Training at entry[2]: 01->10->11->11->10->01->00->00->01->10.
    rows[0] = '{3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    rows[1] = '{3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    rows[2] = '{3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    rows[3] = '{3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    rows[4] = '{3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    rows[5] = '{3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    rows[6] = '{3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    rows[7] = '{3'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    rows[8] = '{3'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset held with an always-taken branch presented.
    rst_n = 1'b0;
    if_pc = 32'h40;
    ex_pc = 32'h2000;
    drive(1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_select", select, 0);
    check("rst_mispredict", mispredict, 0);
    check("rst_flush", flush, 0);
    check("rst_pred_taken", pred_taken, 0);

    // Mode sweep with ex_pred=0, so mispredict mirrors the condition.
    rst_n = 1'b1;
    for (int m = 0; m < 8; m++) begin
      drive(1'b1, 3'(m), 1'b1, 1'b0, 1'b0);
      tick();
      check($sformatf("sweep_z_sel_m%0d", m), select, exp_z[m]);
      check($sformatf("sweep_z_mis_m%0d", m), mispredict, exp_z[m]);
    end
    for (int m = 0; m < 8; m++) begin
      drive(1'b1, 3'(m), 1'b0, 1'b1, 1'b0);
      tick();
      check($sformatf("sweep_n_sel_m%0d", m), select, exp_n[m]);
    end

    // Unresolved: invalid instruction and valid non-branch.
    drive(1'b0, 3'd6, 1'b0, 1'b0, 1'b0);
    tick();
    check("novalid_select", select, 0);
    check("novalid_mispredict", mispredict, 0);
    ex_valid  = 1'b1;
    ex_branch = 1'b0;
    tick();
    check("nobranch_select", select, 0);

    // Fresh table for training.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ex_pc = 32'h1008;
    if_pc = 32'h1008;
    check("train_pred_init", pred_taken, 0);
    for (int r = 0; r < 9; r++) begin
      drive(1'b1, rows[r].mode, rows[r].zero, 1'b0, rows[r].pred);
      tick();
      check($sformatf("train_sel_r%0d", r), select, rows[r].sel);
      check($sformatf("train_mis_r%0d", r), mispredict, DYN ? rows[r].mis_dyn : rows[r].mis_sta);
      check($sformatf("train_pred_r%0d", r), pred_taken, rows[r].pt_dyn & DYN);
      if (r == 2) begin
        if_pc = 32'h1048;
        #1;
        check("alias_pred", pred_taken, DYN);
        if_pc = 32'h1008;
        #1;
      end
    end

    // Flush timing: single mispredict, then back-to-back mispredicts.
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    check("idle_flush", flush, 0);
    drive(1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
    tick();
    ex_valid = 1'b0;
    check("fl1_mis_n", mispredict, 1);
    check("fl1_flush_n", flush, 1);
    tick();
    check("fl1_mis_n1", mispredict, 0);
    check("fl1_flush_n1", flush, 1);
    tick();
    check("fl1_flush_n2", flush, 0);
    ex_valid = 1'b1;
    tick();
    check("fl2_flush_n", flush, 1);
    tick();
    ex_valid = 1'b0;
    check("fl2_mis_n1", mispredict, 1);
    check("fl2_flush_n1", flush, 1);
    tick();
    check("fl2_flush_n2", flush, 1);
    tick();
    check("fl2_flush_n3", flush, 0);

    // Mid-flush reset clears the flush and the table.
    check("pre_rst_pred", pred_taken, DYN);
    ex_valid = 1'b1;
    tick();
    check("mid_flush_set", flush, 1);
    ex_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    check("mid_rst_flush", flush, 0);
    check("mid_rst_mis", mispredict, 0);
    check("mid_rst_pred", pred_taken, 0);
    rst_n = 1'b1;

    // Taken BNE with ex_pred=0 flushes for two cycles; a not-taken branch does not.
    ex_pc = 32'h3000;
    drive(1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    tick();
    ex_valid = 1'b0;
    check("bne_select", select, 1);
    check("bne_mis", mispredict, 1);
    check("bne_flush0", flush, 1);
    tick();
    check("bne_flush1", flush, 1);
    tick();
    check("bne_flush2", flush, 0);
    drive(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    ex_valid = 1'b0;
    check("nt_select", select, 0);
    check("nt_mis", mispredict, 0);
    check("nt_flush", flush, 0);
    tick();
    check("nt_flush1", flush, 0);
    check("end_pred", pred_taken, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
